// File: rtl/musa_ctrl_pkg.sv
// Shared types and encodings for the MUSA multicycle control unit:
// FSM states, the registered control word, select/ALU encodings and opcodes.
package musa_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_MULDIV = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    // Next-PC select
    localparam logic [2:0] PC_RET  = 3'b000;
    localparam logic [2:0] PC_BR   = 3'b001;
    localparam logic [2:0] PC_INC  = 3'b010;
    localparam logic [2:0] PC_JPC  = 3'b011;
    localparam logic [2:0] PC_HALT = 3'b100;

    // ALU operand selects
    localparam logic [1:0] SEL_A_PC   = 2'b00;
    localparam logic [1:0] SEL_A_REG  = 2'b10;
    localparam logic [1:0] SEL_B_IMM  = 2'b00;
    localparam logic [1:0] SEL_B_REG  = 2'b01;
    localparam logic [1:0] SEL_B_JOFF = 2'b10;

    // ALU operation classes
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_BRFL  = 3'b101;
    localparam logic [2:0] ALU_CMP   = 3'b110;

    // Opcodes (instruction[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h01;
    localparam logic [5:0] OP_SW    = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h03;
    localparam logic [5:0] OP_SUBI  = 6'h04;
    localparam logic [5:0] OP_ANDI  = 6'h05;
    localparam logic [5:0] OP_ORI   = 6'h06;
    localparam logic [5:0] OP_JPC   = 6'h07;
    localparam logic [5:0] OP_BRFL  = 6'h08;
    localparam logic [5:0] OP_JR    = 6'h09;
    localparam logic [5:0] OP_CALL  = 6'h0A;
    localparam logic [5:0] OP_RET   = 6'h0B;
    localparam logic [5:0] OP_CMP   = 6'h0C;
    localparam logic [5:0] OP_HALT  = 6'h0D;

    // R-type funct codes that need the multi-cycle unit
    localparam logic [5:0] FN_MULT = 6'h18;
    localparam logic [5:0] FN_DIV  = 6'h1A;

    typedef struct packed {
        logic       reg_dst;
        logic       mem_read;
        logic       mem_to_reg;
        logic [2:0] alu_op;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] data_a_s;
        logic [1:0] data_b_s;
        logic [2:0] pc_src;
        logic       push;
        logic       pop;
        logic       is_mem;
        logic       is_muldiv;
    } ctrl_word_t;

endpackage

// File: rtl/musa_ctrl_if.sv
// Control-unit bus: IR contents and handshakes in, datapath control strobes out.
interface musa_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] instruction;
    logic                  mem_ready;
    logic                  muldiv_done;
    logic                  ir_write;
    logic                  pc_write;
    logic                  reg_dst;
    logic                  mem_read;
    logic                  mem_to_reg;
    logic [2:0]            alu_op;
    logic                  mem_write;
    logic                  reg_write;
    logic [1:0]            data_a_s;
    logic [1:0]            data_b_s;
    logic [2:0]            pc_src;
    logic                  push;
    logic                  pop;
    logic                  muldiv_start;
    logic                  halted;
    logic                  illegal_op;
    logic [2:0]            state;

    modport master (
        input  instruction, mem_ready, muldiv_done,
        output ir_write, pc_write, reg_dst, mem_read, mem_to_reg, alu_op,
               mem_write, reg_write, data_a_s, data_b_s, pc_src, push, pop,
               muldiv_start, halted, illegal_op, state
    );

    modport slave (
        output instruction, mem_ready, muldiv_done,
        input  ir_write, pc_write, reg_dst, mem_read, mem_to_reg, alu_op,
               mem_write, reg_write, data_a_s, data_b_s, pc_src, push, pop,
               muldiv_start, halted, illegal_op, state
    );
endinterface

// File: rtl/musa_ctrl_decode.sv
// Combinational opcode/funct decode into the control word; unknown opcodes
// decode as a NOP with the illegal flag raised.
module musa_ctrl_decode
    import musa_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] instruction,
    output ctrl_word_t            word,
    output logic                  illegal,
    output logic                  halt
);
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_fields;

    assign opcode        = instruction[31:26];
    assign funct         = instruction[5:0];
    assign unused_fields = ^instruction[25:6];

    always_comb begin
        word        = '0;
        word.pc_src = PC_INC;
        illegal     = 1'b0;
        halt        = 1'b0;
        case (opcode)
            OP_SW: begin
                word.data_a_s  = SEL_A_REG;
                word.mem_write = 1'b1;
                word.is_mem    = 1'b1;
            end
            OP_LW: begin
                word.mem_read   = 1'b1;
                word.mem_to_reg = 1'b1;
                word.reg_write  = 1'b1;
                word.is_mem     = 1'b1;
            end
            OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI: begin
                word.data_a_s  = SEL_A_REG;
                word.data_b_s  = SEL_B_IMM;
                word.reg_write = 1'b1;
            end
            OP_JPC: begin
                word.data_b_s = SEL_B_JOFF;
                word.pc_src   = PC_JPC;
            end
            OP_BRFL: begin
                word.alu_op   = ALU_BRFL;
                word.data_a_s = SEL_A_REG;
                word.pc_src   = PC_BR;
            end
            OP_JR:   word.pc_src = PC_BR;
            OP_CALL: begin
                word.push   = 1'b1;
                word.pc_src = PC_BR;
            end
            OP_RET: begin
                word.pop    = 1'b1;
                word.pc_src = PC_RET;
            end
            OP_RTYPE: begin
                word.reg_dst   = 1'b1;
                word.reg_write = 1'b1;
                word.alu_op    = ALU_FUNCT;
                word.data_a_s  = SEL_A_REG;
                word.data_b_s  = SEL_B_REG;
                word.is_muldiv = (funct == FN_MULT) || (funct == FN_DIV);
            end
            OP_CMP: begin
                word.alu_op   = ALU_CMP;
                word.data_a_s = SEL_A_REG;
                word.data_b_s = SEL_B_REG;
            end
            OP_HALT: begin
                word.pc_src = PC_HALT;
                halt        = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/musa_ctrl_fsm.sv
// MUSA multicycle control FSM: FETCH/DECODE/EXEC/MEM/MULDIV/WB/HALT sequencing.
// Define MUSA_CTRL_ILLEGAL_TRAP_EN to trap unknown opcodes into HALT.
module musa_ctrl_fsm
    import musa_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    musa_ctrl_if.master      bus
);
    localparam int             CNT_W   = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_WAIT_MAX);

    state_t           state_reg, state_next;
    ctrl_word_t       ctrl_reg, ctrl_next;
    logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic             done_seen_reg, done_seen_next;
    logic             timeout_reg, timeout_next;
`ifdef MUSA_CTRL_ILLEGAL_TRAP_EN
    logic             trap_reg, trap_next;
`endif

    ctrl_word_t dec_word;
    logic       dec_illegal;
    logic       dec_halt;
    logic       timeout_hit;

    logic ir_write_c, pc_write_c, mem_read_c, mem_write_c, reg_write_c;
    logic push_c, pop_c, muldiv_start_c, halted_c, illegal_c, sel_on;

    musa_ctrl_decode #(.DATA_WIDTH(DATA_WIDTH)) u_decode (
        .instruction (bus.instruction),
        .word        (dec_word),
        .illegal     (dec_illegal),
        .halt        (dec_halt)
    );

    assign timeout_hit = (MEM_WAIT_MAX > 0) && (wait_cnt_reg == CNT_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= S_FETCH;
            ctrl_reg      <= '0;
            wait_cnt_reg  <= '0;
            done_seen_reg <= 1'b0;
            timeout_reg   <= 1'b0;
`ifdef MUSA_CTRL_ILLEGAL_TRAP_EN
            trap_reg      <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            ctrl_reg      <= ctrl_next;
            wait_cnt_reg  <= wait_cnt_next;
            done_seen_reg <= done_seen_next;
            timeout_reg   <= timeout_next;
`ifdef MUSA_CTRL_ILLEGAL_TRAP_EN
            trap_reg      <= trap_next;
`endif
        end
    end

    always_comb begin
        state_next     = state_reg;
        ctrl_next      = ctrl_reg;
        wait_cnt_next  = wait_cnt_reg;
        done_seen_next = done_seen_reg;
        timeout_next   = timeout_reg;
`ifdef MUSA_CTRL_ILLEGAL_TRAP_EN
        trap_next      = trap_reg;
`endif
        ir_write_c     = 1'b0;
        pc_write_c     = 1'b0;
        mem_read_c     = 1'b0;
        mem_write_c    = 1'b0;
        reg_write_c    = 1'b0;
        push_c         = 1'b0;
        pop_c          = 1'b0;
        muldiv_start_c = 1'b0;
        halted_c       = 1'b0;
        illegal_c      = 1'b0;
        sel_on         = 1'b0;

        case (state_reg)
            S_FETCH: begin
                ir_write_c     = 1'b1;
                wait_cnt_next  = '0;
                done_seen_next = 1'b0;
                timeout_next   = 1'b0;
                state_next     = S_DECODE;
            end
            S_DECODE: begin
                ctrl_next = dec_word;
                illegal_c = dec_illegal;
                if (dec_halt) begin
                    state_next = S_HALT;
`ifdef MUSA_CTRL_ILLEGAL_TRAP_EN
                end else if (dec_illegal) begin
                    ctrl_next.pc_src = PC_HALT;
                    trap_next        = 1'b1;
                    state_next       = S_HALT;
`endif
                end else begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                sel_on         = 1'b1;
                push_c         = ctrl_reg.push;
                pop_c          = ctrl_reg.pop;
                muldiv_start_c = ctrl_reg.is_muldiv;
                // An early done pulse must survive until MULDIV looks for it
                if (ctrl_reg.is_muldiv && bus.muldiv_done)
                    done_seen_next = 1'b1;
                if (ctrl_reg.is_mem)
                    state_next = S_MEM;
                else if (ctrl_reg.is_muldiv)
                    state_next = S_MULDIV;
                else
                    state_next = S_WB;
            end
            S_MEM: begin
                sel_on      = 1'b1;
                mem_read_c  = ctrl_reg.mem_read;
                mem_write_c = ctrl_reg.mem_write;
                if (bus.mem_ready) begin
                    if (ctrl_reg.mem_write) begin
                        pc_write_c = 1'b1;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_WB;
                    end
                end else if (timeout_hit) begin
                    illegal_c    = 1'b1;
                    timeout_next = 1'b1;
                    state_next   = S_WB;
                end else begin
                    wait_cnt_next = wait_cnt_reg + CNT_W'(1);
                end
            end
            S_MULDIV: begin
                sel_on = 1'b1;
                if (bus.muldiv_done || done_seen_reg)
                    state_next = S_WB;
            end
            S_WB: begin
                sel_on      = 1'b1;
                reg_write_c = ctrl_reg.reg_write && !timeout_reg;
                pc_write_c  = 1'b1;
                state_next  = S_FETCH;
            end
            S_HALT: begin
                sel_on   = 1'b1;
                halted_c = 1'b1;
`ifdef MUSA_CTRL_ILLEGAL_TRAP_EN
                illegal_c = trap_reg;
`endif
            end
            default: state_next = S_FETCH;
        endcase
    end

    // Outputs are forced low for as long as reset is held, not only after the edge
    logic live, sel_live;
    assign live     = rst_n;
    assign sel_live = rst_n & sel_on;

    assign bus.ir_write     = live & ir_write_c;
    assign bus.pc_write     = live & pc_write_c;
    assign bus.mem_read     = live & mem_read_c;
    assign bus.mem_write    = live & mem_write_c;
    assign bus.reg_write    = live & reg_write_c;
    assign bus.push         = live & push_c;
    assign bus.pop          = live & pop_c;
    assign bus.muldiv_start = live & muldiv_start_c;
    assign bus.halted       = live & halted_c;
    assign bus.illegal_op   = live & illegal_c;
    assign bus.reg_dst      = sel_live & ctrl_reg.reg_dst;
    assign bus.mem_to_reg   = sel_live & ctrl_reg.mem_to_reg;
    assign bus.alu_op       = sel_live ? ctrl_reg.alu_op   : 3'b000;
    assign bus.data_a_s     = sel_live ? ctrl_reg.data_a_s : 2'b00;
    assign bus.data_b_s     = sel_live ? ctrl_reg.data_b_s : 2'b00;
    assign bus.pc_src       = sel_live ? ctrl_reg.pc_src   : 3'b000;
    assign bus.state        = state_reg;
endmodule

// File: tb/tb_musa_ctrl_fsm.sv
// Randomized self-checking bench for musa_ctrl_fsm against a per-instruction
// timeline model built from the instruction-class rules.
module tb_musa_ctrl_fsm;
    import musa_ctrl_pkg::*;

    localparam int MWM = 15;
`ifdef MUSA_CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    musa_ctrl_if #(.DATA_WIDTH(32)) bus ();

    musa_ctrl_fsm #(.DATA_WIDTH(32), .MEM_WAIT_MAX(MWM)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic       ir_write, pc_write, reg_dst, mem_read, mem_to_reg;
        logic [2:0] alu_op;
        logic       mem_write, reg_write;
        logic [1:0] data_a_s, data_b_s;
        logic [2:0] pc_src;
        logic       push, pop, muldiv_start, halted, illegal_op;
        logic [2:0] state;
    } obs_t;

    // Expected behaviour of one instruction class
    typedef struct packed {
        logic       rd, m2r;
        logic [2:0] alu;
        logic [1:0] da, db;
        logic [2:0] pc;
        logic       rw, push, pop, lw, sw, md, halt, bad;
    } w_t;

    int n_checks = 0;
    int n_errors = 0;
    int txn      = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s txn=%0d cyc=%0d: got %h want %h", tag, txn, cyc, got, want);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.ir_write     = bus.ir_write;
        o.pc_write     = bus.pc_write;
        o.reg_dst      = bus.reg_dst;
        o.mem_read     = bus.mem_read;
        o.mem_to_reg   = bus.mem_to_reg;
        o.alu_op       = bus.alu_op;
        o.mem_write    = bus.mem_write;
        o.reg_write    = bus.reg_write;
        o.data_a_s     = bus.data_a_s;
        o.data_b_s     = bus.data_b_s;
        o.pc_src       = bus.pc_src;
        o.push         = bus.push;
        o.pop          = bus.pop;
        o.muldiv_start = bus.muldiv_start;
        o.halted       = bus.halted;
        o.illegal_op   = bus.illegal_op;
        o.state        = bus.state;
        return o;
    endfunction

    function automatic obs_t base(input logic [2:0] st);
        obs_t o = '0;
        o.state = st;
        return o;
    endfunction

    function automatic obs_t with_sel(input obs_t o_in, input w_t w);
        obs_t o = o_in;
        o.reg_dst    = w.rd;
        o.mem_to_reg = w.m2r;
        o.alu_op     = w.alu;
        o.data_a_s   = w.da;
        o.data_b_s   = w.db;
        o.pc_src     = w.pc;
        return o;
    endfunction

    function automatic w_t rules(input logic [5:0] op, input logic [5:0] fn);
        w_t w = '0;
        w.pc = 3'b010;
        case (op)
            OP_SW:   begin w.da = 2'b10; w.sw = 1'b1; end
            OP_LW:   begin w.lw = 1'b1; w.m2r = 1'b1; w.rw = 1'b1; end
            OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI: begin w.da = 2'b10; w.db = 2'b00; w.rw = 1'b1; end
            OP_JPC:  begin w.db = 2'b10; w.pc = 3'b011; end
            OP_BRFL: begin w.alu = 3'b101; w.da = 2'b10; w.pc = 3'b001; end
            OP_JR:   w.pc = 3'b001;
            OP_CALL: begin w.push = 1'b1; w.pc = 3'b001; end
            OP_RET:  begin w.pop = 1'b1; w.pc = 3'b000; end
            OP_RTYPE: begin
                w.rd = 1'b1; w.rw = 1'b1; w.alu = 3'b010; w.da = 2'b10; w.db = 2'b01;
                w.md = (fn == FN_MULT) || (fn == FN_DIV);
            end
            OP_CMP:  begin w.alu = 3'b110; w.da = 2'b10; w.db = 2'b01; end
            OP_HALT: begin w.pc = 3'b100; w.halt = 1'b1; end
            default: w.bad = 1'b1;
        endcase
        return w;
    endfunction

    // Inputs for the current cycle are set by the caller before calling step
    task automatic step(input string tag, input obs_t e);
        @(negedge clk);
        check(tag, {7'd0, sample()}, {7'd0, e});
        cyc++;
        @(posedge clk);
        #1;
        bus.mem_ready   = 1'b0;
        bus.muldiv_done = 1'b0;
    endtask

    task automatic run(input logic [5:0] op, input logic [5:0] fn, input int mwait, input int dwait);
        w_t   w = rules(op, fn);
        obs_t e;
        logic timeout = 1'b0;
        logic [19:0] mid = 20'($urandom);
        cyc = 0;
        txn++;
        bus.instruction = {op, mid, fn};

        e = base(S_FETCH); e.ir_write = 1'b1;
        step("fetch", e);
        e = base(S_DECODE); e.illegal_op = w.bad;
        step("decode", e);

        if (w.halt || (TRAP && w.bad)) begin
            for (int i = 0; i < 4; i++) begin
                bus.mem_ready   = 1'($urandom_range(0, 1));
                bus.muldiv_done = 1'($urandom_range(0, 1));
                e = base(S_HALT); e.pc_src = 3'b100; e.halted = 1'b1; e.illegal_op = w.bad;
                step("halt", e);
            end
            rst_n = 1'b0;
            step("halt_rst", base(S_HALT));
            rst_n = 1'b1;
        end else begin
            e = with_sel(base(S_EXEC), w);
            e.push = w.push; e.pop = w.pop; e.muldiv_start = w.md;
            if (w.md && dwait == 0) bus.muldiv_done = 1'b1;
            step("exec", e);

            if (w.lw || w.sw) begin
                for (int i = 0; i < 64; i++) begin
                    bus.mem_ready = (i == mwait);
                    e = with_sel(base(S_MEM), w);
                    e.mem_read = w.lw; e.mem_write = w.sw;
                    if (i == mwait) begin
                        e.pc_write = w.sw;
                        step("mem_done", e);
                        break;
                    end else if (i == MWM) begin
                        e.illegal_op = 1'b1;
                        timeout = 1'b1;
                        step("mem_tmo", e);
                        break;
                    end
                    step("mem_wait", e);
                end
            end else if (w.md) begin
                for (int i = 1; i < 64; i++) begin
                    bus.muldiv_done = (i == dwait);
                    step("muldiv", base(S_MULDIV) | with_sel('0, w));
                    if (i >= dwait) break;
                end
            end

            if (!(w.sw && !timeout)) begin
                e = with_sel(base(S_WB), w);
                e.reg_write = w.rw && !timeout;
                e.pc_write  = 1'b1;
                step("wb", e);
            end
        end
        $display("txn %0d op=%02h fn=%02h mwait=%0d dwait=%0d cycles=%0d errors=%0d",
                 txn, op, fn, mwait, dwait, cyc, n_errors);
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.instruction = '0;
        bus.mem_ready   = 1'b0;
        bus.muldiv_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        step("reset", base(S_FETCH));
        rst_n = 1'b1;

        run(OP_ADDI, 6'h00, 0, 0);
        run(OP_LW, 6'h00, 3, 0);
        run(OP_RTYPE, FN_MULT, 0, 6);
        run(OP_CALL, 6'h00, 0, 0);
        run(OP_RET, 6'h00, 0, 0);
        run(OP_RTYPE, FN_DIV, 0, 0);
        run(OP_SW, 6'h00, 0, 0);
        run(OP_SW, 6'h00, 2, 0);
        run(OP_LW, 6'h00, 99, 0);
        run(OP_SW, 6'h00, 99, 0);
        run(6'h3F, 6'h00, 0, 0);
        run(OP_JPC, 6'h00, 0, 0);
        run(OP_BRFL, 6'h00, 0, 0);
        run(OP_CMP, 6'h00, 0, 0);
        run(OP_JR, 6'h00, 0, 0);
        run(OP_RTYPE, 6'h20, 0, 0);
        run(OP_HALT, 6'h00, 0, 0);

        for (int k = 0; k < 60; k++) begin
            logic [5:0] op, fn;
            int r  = int'($urandom_range(0, 15));
            int mw = (($urandom_range(0, 7)) == 0) ? 99 : int'($urandom_range(0, 4));
            int dw = int'($urandom_range(0, 7));
            op = (r < 14) ? 6'(r) : 6'($urandom_range(14, 63));
            case ($urandom_range(0, 2))
                0:       fn = FN_MULT;
                1:       fn = FN_DIV;
                default: fn = 6'($urandom);
            endcase
            run(op, fn, mw, dw);
        end

        run(OP_HALT, 6'h00, 0, 0);
        run(OP_ADDI, 6'h00, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
